// File: rtl/note_scheduler.sv
// Song clock and ring-buffered note window loader for the display; one read in flight on the song-memory port.
// Optional macro PAUSE_EN enables the pause input (otherwise pause is ignored).
module note_scheduler #(
    parameter int DISPLAYED_BEATS    = 2,
    parameter int SIMULTANEOUS_NOTES = 2,
    parameter int BEAT_DURATION      = 4,
    parameter int BEAT_BITS          = 8,
    parameter int NOTE_BITS          = 7,
    parameter int TIME_BITS          = 32,
    parameter int ADDR_BITS          = 12,
    localparam int NOTE_STATE_BITS   = NOTE_BITS + 2*BEAT_BITS,
    localparam int W                 = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_stop,
    input  logic                             i_pause,
    input  logic [BEAT_BITS-1:0]             i_song_len,
    output logic                             o_mem_rd,
    output logic [ADDR_BITS-1:0]             o_mem_addr,
    input  logic                             i_mem_ack,
    input  logic [NOTE_STATE_BITS-1:0]       i_mem_data,
    output logic [W-1:0][NOTE_STATE_BITS-1:0] o_notes,
    output logic [TIME_BITS-1:0]             o_cur_time,
    output logic [BEAT_BITS-1:0]             o_cur_beat,
    output logic                             o_valid,
    output logic                             o_done,
    output logic                             o_overrun
);
    localparam int S         = SIMULTANEOUS_NOTES;
    localparam int RING      = 2*DISPLAYED_BEATS;
    localparam int IDX_BITS  = $clog2(W);
    localparam int SLOT_BITS = $clog2(S+1);
    localparam int TIB_BITS  = $clog2(BEAT_DURATION+1);

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_RUN, S_REFILL, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [W-1:0][NOTE_STATE_BITS-1:0] r_notes;
    logic [TIME_BITS-1:0] r_cur_time;
    logic [BEAT_BITS-1:0] r_cur_beat, r_ld_beat, r_pend_beat;
    logic [TIB_BITS-1:0]  r_tib;
    logic [SLOT_BITS-1:0] r_ld_slot;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic                 r_mem_rd, r_pending, r_overrun;

    logic w_pause, w_run, w_tick, w_end, w_loading, w_slot_done, w_last, w_ld_fin, w_start_acc;
    logic w_pos_set;
    logic [BEAT_BITS-1:0] w_new_beat, w_tick_tgt, w_pos_beat;
    logic [SLOT_BITS-1:0] w_pos_slot;
    logic [IDX_BITS-1:0]  w_wr_idx, w_old_base;

`ifdef PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = i_pause & 1'b0;
`endif

    assign w_run       = (r_state == S_RUN || r_state == S_REFILL) && !w_pause;
    assign w_tick      = w_run && (r_tib == TIB_BITS'(BEAT_DURATION-1));
    assign w_new_beat  = r_cur_beat + BEAT_BITS'(1);
    assign w_end       = w_tick && (w_new_beat == i_song_len);
    assign w_tick_tgt  = r_cur_beat + BEAT_BITS'(RING);
    assign w_loading   = (r_state == S_PRELOAD || r_state == S_REFILL);
    // A slot completes on ack, or in one cycle when it is a zero-fill (no read issued).
    assign w_slot_done = w_loading && (!r_mem_rd || i_mem_ack);
    assign w_last      = (r_ld_slot == SLOT_BITS'(S-1)) &&
                         (r_state == S_REFILL || r_ld_beat == BEAT_BITS'(RING-1));
    assign w_ld_fin    = w_slot_done && w_last;
    assign w_start_acc = i_start && !i_stop && (r_state == S_IDLE || r_state == S_DONE);
    assign w_wr_idx    = IDX_BITS'((32'(r_ld_beat) % RING) * S + 32'(r_ld_slot));
    assign w_old_base  = IDX_BITS'((32'(r_cur_beat) % RING) * S);

    always_comb begin
        w_pos_set  = 1'b0;
        w_pos_beat = r_ld_beat;
        w_pos_slot = '0;
        if (w_start_acc) begin
            w_pos_set  = 1'b1;
            w_pos_beat = '0;
        end else if (r_state == S_RUN && w_tick && !w_end) begin
            w_pos_set  = 1'b1;
            w_pos_beat = w_tick_tgt;
        end else if (w_slot_done && !w_last) begin
            w_pos_set = 1'b1;
            if (r_ld_slot == SLOT_BITS'(S-1)) w_pos_beat = r_ld_beat + BEAT_BITS'(1);
            else                              w_pos_slot = r_ld_slot + SLOT_BITS'(1);
        end else if (r_state == S_REFILL && w_ld_fin && !w_end) begin
            if (r_pending) begin
                w_pos_set  = 1'b1;
                w_pos_beat = r_pend_beat;
            end else if (w_tick) begin
                w_pos_set  = 1'b1;
                w_pos_beat = w_tick_tgt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_state_nxt = S_PRELOAD;
            S_PRELOAD:      if (w_ld_fin) w_state_nxt = (i_song_len == '0) ? S_DONE : S_RUN;
            S_RUN:          if (w_end) w_state_nxt = S_DONE;
                            else if (w_tick) w_state_nxt = S_REFILL;
            S_REFILL:       if (w_end) w_state_nxt = S_DONE;
                            else if (w_ld_fin && !r_pending && !w_tick) w_state_nxt = S_RUN;
            default:        w_state_nxt = S_IDLE;
        endcase
        if (i_stop) w_state_nxt = S_IDLE;
    end

    always_comb begin
        o_valid = (r_state == S_RUN) || (r_state == S_REFILL) || (r_state == S_DONE);
        o_done  = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop) begin
            r_notes     <= '0;
            r_cur_time  <= '0;
            r_cur_beat  <= '0;
            r_tib       <= '0;
            r_ld_beat   <= '0;
            r_ld_slot   <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_pending   <= 1'b0;
            r_pend_beat <= '0;
            if (i_rst) r_overrun <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_notes    <= '0;
                r_cur_time <= '0;
                r_cur_beat <= '0;
                r_tib      <= '0;
                r_pending  <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_run) begin
                r_cur_time <= r_cur_time + TIME_BITS'(1);
                if (w_tick) begin
                    r_tib      <= '0;
                    r_cur_beat <= w_new_beat;
                end else begin
                    r_tib <= r_tib + TIB_BITS'(1);
                end
            end
            if (w_slot_done) r_notes[w_wr_idx] <= r_mem_rd ? i_mem_data : '0;
            // Retiring beat is cleared last so a stale load can never resurrect it.
            if (w_tick) begin
                for (int s = 0; s < S; s++) r_notes[w_old_base + IDX_BITS'(s)] <= '0;
            end
            if (r_state == S_REFILL && !w_end) begin
                if (w_ld_fin) begin
                    if (r_pending) begin
                        r_pending   <= w_tick;
                        r_pend_beat <= w_tick_tgt;
                    end
                end else if (w_tick) begin
                    if (r_pending) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_pending   <= 1'b1;
                        r_pend_beat <= w_tick_tgt;
                    end
                end
            end
            if (w_pos_set) begin
                r_ld_beat  <= w_pos_beat;
                r_ld_slot  <= w_pos_slot;
                r_mem_rd   <= (w_pos_beat < i_song_len);
                r_mem_addr <= ADDR_BITS'(32'(w_pos_beat) * S + 32'(w_pos_slot));
            end else if (w_slot_done) begin
                r_mem_rd <= 1'b0;
            end
            if (w_end) begin
                r_mem_rd  <= 1'b0;
                r_pending <= 1'b0;
            end
        end
    end

    assign o_notes    = r_notes;
    assign o_cur_time = r_cur_time;
    assign o_cur_beat = r_cur_beat;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_overrun  = r_overrun;
endmodule
